// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the flexible synchronous FIFO.
// Read-mode selectors and the pointer width (index bits plus one wrap bit).
package fifo_pkg;

   localparam int FIFO_STD  = 0;
   localparam int FIFO_FWFT = 1;

   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
// No reset on the array; the control logic never reads an unwritten word.
module fifo_ram #(
   parameter int FIFO_WIDTH = 32,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk_i,
   input  logic                          we,
   input  logic [$clog2(FIFO_DEPTH)-1:0] waddr,
   input  logic [FIFO_WIDTH-1:0]         wdata,
   input  logic [$clog2(FIFO_DEPTH)-1:0] raddr,
   output logic [FIFO_WIDTH-1:0]         rdata
);

   logic [FIFO_WIDTH-1:0] mem_array [FIFO_DEPTH];

   always_ff @(posedge clk_i) begin
      if (we) begin
         mem_array[waddr] <= wdata;
      end
   end

   assign rdata = mem_array[raddr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Synchronous FIFO with wrap-bit pointers, selectable standard or FWFT read,
// programmable almost-full/almost-empty thresholds and sticky error flags.
module sync_fifo_flex
   import fifo_pkg::*;
#(
   parameter int FIFO_WIDTH = 32,
   parameter int FIFO_DEPTH = 16,
   parameter int FWFT       = 0,
   parameter int AF_LEVEL   = FIFO_DEPTH - 2,
   parameter int AE_LEVEL   = 2
) (
   input  logic                            clk_i,
   input  logic                            rstn_i,
   input  logic                            wr_en_i,
   input  logic [FIFO_WIDTH-1:0]           din_i,
   input  logic                            rd_en_i,
   input  logic                            flush_i,
   output logic [FIFO_WIDTH-1:0]           dout_o,
   output logic                            full_o,
   output logic                            empty_o,
   output logic                            almost_full_o,
   output logic                            almost_empty_o,
   output logic [$clog2(FIFO_DEPTH):0]     count_o,
   output logic                            overflow_o,
   output logic                            underflow_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = ptr_width(FIFO_DEPTH);
   localparam logic [PW-1:0] AF_THR = PW'(AF_LEVEL);
   localparam logic [PW-1:0] AE_THR = PW'(AE_LEVEL);

   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("sync_fifo_flex: FIFO_DEPTH must be a power of 2 and >= 2");
   end
   if (FIFO_WIDTH < 1) begin : g_bad_width
      $error("sync_fifo_flex: FIFO_WIDTH must be >= 1");
   end
   if ((AF_LEVEL < 1) || (AF_LEVEL > FIFO_DEPTH)) begin : g_bad_af
      $error("sync_fifo_flex: AF_LEVEL out of range 1..FIFO_DEPTH");
   end
   if ((AE_LEVEL < 0) || (AE_LEVEL > FIFO_DEPTH - 1)) begin : g_bad_ae
      $error("sync_fifo_flex: AE_LEVEL out of range 0..FIFO_DEPTH-1");
   end
   if ((FWFT != FIFO_STD) && (FWFT != FIFO_FWFT)) begin : g_bad_mode
      $error("sync_fifo_flex: FWFT must be 0 or 1");
   end

   logic [PW-1:0]         wr_ptr_reg, wr_ptr_next;
   logic [PW-1:0]         rd_ptr_reg, rd_ptr_next;
   logic                  overflow_reg, overflow_next;
   logic                  underflow_reg, underflow_next;
   logic                  wr_accept, rd_accept;
   logic [FIFO_WIDTH-1:0] ram_rdata;

   // Full when indices match but the wrap bits differ; empty when identical.
   assign full_o  = (wr_ptr_reg[PW-1] != rd_ptr_reg[PW-1]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign empty_o = (wr_ptr_reg == rd_ptr_reg);
   assign count_o = wr_ptr_reg - rd_ptr_reg;

   assign almost_full_o  = (count_o >= AF_THR);
   assign almost_empty_o = (count_o <= AE_THR);
   assign overflow_o     = overflow_reg;
   assign underflow_o    = underflow_reg;

   assign wr_accept = wr_en_i && !full_o  && !flush_i;
   assign rd_accept = rd_en_i && !empty_o && !flush_i;

   always_comb begin
      wr_ptr_next    = wr_ptr_reg;
      rd_ptr_next    = rd_ptr_reg;
      overflow_next  = overflow_reg;
      underflow_next = underflow_reg;
      if (flush_i) begin
         wr_ptr_next    = '0;
         rd_ptr_next    = '0;
         overflow_next  = 1'b0;
         underflow_next = 1'b0;
      end else begin
         if (wr_accept) wr_ptr_next = wr_ptr_reg + PW'(1);
         if (rd_accept) rd_ptr_next = rd_ptr_reg + PW'(1);
         if (wr_en_i && full_o)  overflow_next  = 1'b1;
         if (rd_en_i && empty_o) underflow_next = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         wr_ptr_reg    <= wr_ptr_next;
         rd_ptr_reg    <= rd_ptr_next;
         overflow_reg  <= overflow_next;
         underflow_reg <= underflow_next;
      end
   end

   fifo_ram #(
      .FIFO_WIDTH (FIFO_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_ram (
      .clk_i (clk_i),
      .we    (wr_accept && rstn_i),
      .waddr (wr_ptr_reg[AW-1:0]),
      .wdata (din_i),
      .raddr (rd_ptr_reg[AW-1:0]),
      .rdata (ram_rdata)
   );

   // FWFT shows the head word directly; standard mode captures it on a pop.
   if (FWFT == FIFO_FWFT) begin : g_fwft
      assign dout_o = ram_rdata;
   end else begin : g_std
      logic [FIFO_WIDTH-1:0] dout_reg;
      always_ff @(posedge clk_i) begin
         if (!rstn_i) begin
            dout_reg <= '0;
         end else if (flush_i) begin
            dout_reg <= '0;
         end else if (rd_accept) begin
            dout_reg <= ram_rdata;
         end
      end
      assign dout_o = dout_reg;
   end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Drives a standard-read and an FWFT instance with identical stimulus and
// compares both against a queue-based model of the FIFO behaviour.
module tb_sync_fifo_flex;

   localparam int W  = 8;
   localparam int D  = 4;
   localparam int AF = 3;
   localparam int AE = 1;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         wr_en = 1'b0;
   logic         rd_en = 1'b0;
   logic         flush = 1'b0;
   logic [W-1:0] din = '0;

   logic [W-1:0] s_dout, f_dout;
   logic         s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
   logic         f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
   logic [2:0]   s_count, f_count;

   int total  = 0;
   int passed = 0;

   logic [W-1:0] q[$];
   bit           ovf_m, unf_m;
   logic [W-1:0] dstd_m;

   always #5 clk = ~clk;

   sync_fifo_flex #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .FWFT(0), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_std (
      .clk_i(clk), .rstn_i(rstn), .wr_en_i(wr_en), .din_i(din), .rd_en_i(rd_en), .flush_i(flush),
      .dout_o(s_dout), .full_o(s_full), .empty_o(s_empty), .almost_full_o(s_af),
      .almost_empty_o(s_ae), .count_o(s_count), .overflow_o(s_ovf), .underflow_o(s_unf));

   sync_fifo_flex #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .FWFT(1), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_fwft (
      .clk_i(clk), .rstn_i(rstn), .wr_en_i(wr_en), .din_i(din), .rd_en_i(rd_en), .flush_i(flush),
      .dout_o(f_dout), .full_o(f_full), .empty_o(f_empty), .almost_full_o(f_af),
      .almost_empty_o(f_ae), .count_o(f_count), .overflow_o(f_ovf), .underflow_o(f_unf));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic model_step(input bit r_n, input bit w, input bit r, input bit f, input logic [W-1:0] d);
      int n;
      n = q.size();
      if (!r_n || f) begin
         q.delete();
         ovf_m  = 1'b0;
         unf_m  = 1'b0;
         dstd_m = '0;
      end else begin
         if (w && n == D) ovf_m = 1'b1;
         if (r && n == 0) unf_m = 1'b1;
         if (r && n > 0) dstd_m = q.pop_front();
         if (w && n < D) q.push_back(d);
      end
   endtask

   task automatic check_all();
      int n;
      n = q.size();
      chk("std_count",  32'(s_count), 32'(n));
      chk("std_full",   32'(s_full),  32'(n == D));
      chk("std_empty",  32'(s_empty), 32'(n == 0));
      chk("std_afull",  32'(s_af),    32'(n >= AF));
      chk("std_aempty", 32'(s_ae),    32'(n <= AE));
      chk("std_ovf",    32'(s_ovf),   32'(ovf_m));
      chk("std_unf",    32'(s_unf),   32'(unf_m));
      chk("std_dout",   32'(s_dout),  32'(dstd_m));
      chk("fwft_count", 32'(f_count), 32'(n));
      chk("fwft_full",  32'(f_full),  32'(n == D));
      chk("fwft_empty", 32'(f_empty), 32'(n == 0));
      chk("fwft_ovf",   32'(f_ovf),   32'(ovf_m));
      chk("fwft_unf",   32'(f_unf),   32'(unf_m));
      if (n > 0) chk("fwft_dout", 32'(f_dout), 32'(q[0]));
   endtask

   task automatic cycle(input bit r_n, input bit w, input bit r, input bit f, input logic [W-1:0] d);
      rstn  = r_n;
      wr_en = w;
      rd_en = r;
      flush = f;
      din   = d;
      @(posedge clk);
      model_step(r_n, w, r, f, d);
      #1;
      check_all();
      $display("t=%0t rstn=%0b wr=%0b rd=%0b fl=%0b din=%02h | cnt=%0d std_dout=%02h fwft_dout=%02h ovf=%0b unf=%0b",
               $time, r_n, w, r, f, d, s_count, s_dout, f_dout, s_ovf, s_unf);
   endtask

   initial begin
      logic [W-1:0] fill_vals [4];
      fill_vals = '{8'h11, 8'h22, 8'h33, 8'h44};
      q.delete();
      ovf_m = 1'b0; unf_m = 1'b0; dstd_m = '0;

      // reset state
      cycle(0, 0, 0, 0, 8'h00);
      cycle(1, 0, 0, 0, 8'h00);

      // fill to full, then one refused write
      for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, fill_vals[i]);
      cycle(1, 1, 0, 0, 8'h55);

      // drain, then one refused read
      for (int i = 0; i < 4; i++) cycle(1, 0, 1, 0, 8'h00);
      cycle(1, 0, 1, 0, 8'h00);
      chk("drain_hold", 32'(s_dout), 32'h44);

      // clear sticky flags, then FWFT fall-through
      cycle(1, 0, 0, 1, 8'h00);
      cycle(1, 1, 0, 0, 8'hA5);
      chk("fwft_fall", 32'(f_dout), 32'hA5);
      cycle(1, 0, 1, 0, 8'h00);
      chk("fwft_pop_empty", 32'(f_empty), 32'd1);

      // wrap: hold count at 2 with simultaneous read and write
      cycle(1, 1, 0, 0, 8'($urandom));
      cycle(1, 1, 0, 0, 8'($urandom));
      for (int i = 0; i < 10; i++) cycle(1, 1, 1, 0, 8'($urandom));
      chk("wrap_count", 32'(s_count), 32'd2);

      // flush with a same-cycle write at count 3
      cycle(1, 1, 0, 0, 8'h01);
      cycle(1, 1, 1, 1, 8'h02);
      chk("flush_count", 32'(s_count), 32'd0);
      for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 8'(8'h60 + i));
      cycle(1, 1, 0, 0, 8'h70);
      cycle(1, 1, 0, 0, 8'h71);
      cycle(0, 1, 1, 1, 8'h72);
      chk("reset_count", 32'(s_count), 32'd0);

      // randomized traffic
      for (int i = 0; i < 200; i++) begin
         cycle(($urandom_range(0, 99) != 0), $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
               ($urandom_range(0, 39) == 0), 8'($urandom));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
